// File: rtl/uart_alu_ctrl_pkg.sv
// uart_alu_ctrl_pkg: controller FSM states and ALU opcode constants shared with the ALU
package uart_alu_ctrl_pkg;
  typedef enum logic [2:0] {GET_A, GET_B, GET_OP, EXEC, SEND} state_t;
  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_NOR = 6'b100111;
endpackage

// File: rtl/uart_alu_ctrl_timeout.sv
// uart_alu_ctrl_timeout: inter-byte idle counter (en_i counts, clr_i clears, expired_o on the CYC-th counted cycle)
module uart_alu_ctrl_timeout #(
  parameter int CYC = 0
) (
  input  logic i_clk,
  input  logic reset,
  input  logic en_i,
  input  logic clr_i,
  output logic expired_o
);
  localparam int W = CYC > 0 ? $clog2(CYC + 1) : 1;
  localparam logic [W-1:0] LAST = W'(CYC > 0 ? CYC - 1 : 0);
  logic [W-1:0] cnt_q, cnt_d;
  assign expired_o = CYC > 0 && en_i && cnt_q == LAST;
  always_comb cnt_d = clr_i || expired_o ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge i_clk) cnt_q <= !reset ? '0 : cnt_d;
endmodule

// File: rtl/uart_alu_ctrl.sv
// uart_alu_ctrl: pops A, B, opcode from the RX FIFO, drives the ALU, pushes the result to the TX FIFO
module uart_alu_ctrl
  import uart_alu_ctrl_pkg::*;
#(
  parameter int DBIT        = 8,
  parameter int NB_OP       = 6,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic             i_clk,
  input  logic             reset,
  input  logic             i_rx_empty,
  input  logic [DBIT-1:0]  i_r_data,
  output logic             o_rd_uart,
  input  logic             i_tx_full,
  output logic             o_wr_uart,
  output logic [DBIT-1:0]  o_w_data,
  output logic [DBIT-1:0]  o_alu_a,
  output logic [DBIT-1:0]  o_alu_b,
  output logic [NB_OP-1:0] o_alu_op,
  input  logic [DBIT-1:0]  i_alu_result,
  output logic             o_busy,
  output logic             o_err_timeout
);
  state_t state_q, state_d;
  logic [DBIT-1:0] a_q, b_q, w_q;
  logic [NB_OP-1:0] op_q;
  logic err_q, expired, pop, push, get;
  assign get = state_q == GET_A || state_q == GET_B || state_q == GET_OP;
  assign pop = reset && get && !i_rx_empty;
  assign push = reset && state_q == SEND && !i_tx_full;
  assign o_rd_uart = pop;
  assign o_wr_uart = push;
  assign o_w_data = w_q;
  assign o_alu_a = a_q;
  assign o_alu_b = b_q;
  assign o_alu_op = op_q;
  assign o_busy = state_q != GET_A;
  assign o_err_timeout = err_q;
  uart_alu_ctrl_timeout #(.CYC(TIMEOUT_CYC)) u_tmo (
    .i_clk,
    .reset,
    .en_i((state_q == GET_B || state_q == GET_OP) && i_rx_empty),
    .clr_i(pop || state_q == GET_A),
    .expired_o(expired)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      GET_A:   state_d = pop ? GET_B : GET_A;
      GET_B:   state_d = pop ? GET_OP : expired ? GET_A : GET_B;
      GET_OP:  state_d = pop ? EXEC : expired ? GET_A : GET_OP;
      EXEC:    state_d = SEND;
      SEND:    state_d = push ? GET_A : SEND;
      default: state_d = GET_A;
    endcase
  end
  always_ff @(posedge i_clk)
    if (!reset) begin
      state_q <= GET_A;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      w_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q <= expired;
      if (pop && state_q == GET_A) a_q <= i_r_data;
      if (pop && state_q == GET_B) b_q <= i_r_data;
      if (pop && state_q == GET_OP) op_q <= i_r_data[NB_OP-1:0];
      if (state_q == EXEC) w_q <= i_alu_result;
    end
endmodule

// File: tb/tb_uart_alu_ctrl.sv
// tb_uart_alu_ctrl: directed vectors and corner sequences for uart_alu_ctrl (unit 0 no timeout, unit 1 timeout 50)
module tb_uart_alu_ctrl;
  import uart_alu_ctrl_pkg::*;
  typedef struct {
    logic [7:0] a, b, opb, res;
  } vec_t;
  logic clk;
  logic rst_n [2];
  logic rx_empty [2];
  logic [7:0] r_data [2];
  logic rd [2];
  logic tx_full [2];
  logic wr [2];
  logic [7:0] w_data [2];
  logic [7:0] alu_a [2];
  logic [7:0] alu_b [2];
  logic [5:0] alu_op [2];
  logic [7:0] res [2];
  logic busy [2];
  logic err [2];
  int total = 0, bad = 0, cyc = 0;
  int pushes [2] = '{0, 0};
  int pops [2] = '{0, 0};
  int errs [2] = '{0, 0};
  int err_cyc [2] = '{0, 0};
  int viol [2] = '{0, 0};
  vec_t vt [9];
  function automatic logic [7:0] alu(logic [7:0] a, logic [7:0] b, logic [5:0] op);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SRA:  return $signed(a) >>> b;
      OP_SRL:  return a >> b;
      OP_NOR:  return ~(a | b);
      default: return 8'h00;
    endcase
  endfunction
  for (genvar g = 0; g < 2; g++) begin : g_dut
    uart_alu_ctrl #(.DBIT(8), .NB_OP(6), .TIMEOUT_CYC(g == 0 ? 0 : 50)) dut (
      .i_clk(clk),
      .reset(rst_n[g]),
      .i_rx_empty(rx_empty[g]),
      .i_r_data(r_data[g]),
      .o_rd_uart(rd[g]),
      .i_tx_full(tx_full[g]),
      .o_wr_uart(wr[g]),
      .o_w_data(w_data[g]),
      .o_alu_a(alu_a[g]),
      .o_alu_b(alu_b[g]),
      .o_alu_op(alu_op[g]),
      .i_alu_result(res[g]),
      .o_busy(busy[g]),
      .o_err_timeout(err[g])
    );
    assign res[g] = alu(alu_a[g], alu_b[g], alu_op[g]);
  end
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    for (int u = 0; u < 2; u++) begin
      if (wr[u]) pushes[u]++;
      if (rd[u]) pops[u]++;
      if (err[u]) begin
        errs[u]++;
        err_cyc[u] = cyc;
      end
      if ((rd[u] && rx_empty[u]) || (wr[u] && tx_full[u])) viol[u]++;
    end
  function automatic void chk(string n, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, exp);
    end
  endfunction
  function automatic void fail(string n);
    total++;
    bad++;
    $display("FAIL %s: bound expired", n);
  endfunction
  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic put_byte(input int u, input logic [7:0] d, output int pc);
    rx_empty[u] = 0;
    r_data[u] = d;
    pc = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (rd[u]) begin
        pc = cyc;
        tick();
        return;
      end
    end
    fail("pop_wait");
  endtask
  task automatic wait_push(input int u, input int budget, output int pc, output logic [7:0] d);
    pc = -1;
    d = 8'h00;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (wr[u]) begin
        pc = cyc;
        d = w_data[u];
        tick();
        return;
      end
    end
    fail("push_wait");
  endtask
  task automatic frame(input int u, input string n, input logic [7:0] a, b, opb, r);
    int p1, p2, p3, pc, n0;
    logic [7:0] d;
    n0 = pushes[u];
    put_byte(u, a, p1);
    put_byte(u, b, p2);
    put_byte(u, opb, p3);
    rx_empty[u] = 1;
    chk({n, "_gap_ab"}, p2 - p1, 1);
    chk({n, "_gap_bop"}, p3 - p2, 1);
    chk({n, "_alu_a"}, alu_a[u], a);
    chk({n, "_alu_b"}, alu_b[u], b);
    chk({n, "_alu_op"}, alu_op[u], opb[5:0]);
    wait_push(u, 20, pc, d);
    chk({n, "_latency"}, pc - p3, 2);
    chk({n, "_result"}, d, r);
    chk({n, "_npush"}, pushes[u] - n0, 1);
  endtask
  initial begin
    int p1, p2, p3, pc, n0, e0, q0;
    logic [7:0] d;
    vt[0] = '{8'h05, 8'h03, 8'h20, 8'h08};
    vt[1] = '{8'h0F, 8'hF0, 8'h24, 8'h00};
    vt[2] = '{8'h07, 8'h02, 8'h22, 8'h05};
    vt[3] = '{8'hA5, 8'h0F, 8'h25, 8'hAF};
    vt[4] = '{8'hFF, 8'h0F, 8'h26, 8'hF0};
    vt[5] = '{8'h80, 8'h02, 8'h03, 8'hE0};
    vt[6] = '{8'h80, 8'h02, 8'h02, 8'h20};
    vt[7] = '{8'h01, 8'h02, 8'h27, 8'hFC};
    vt[8] = '{8'h10, 8'h20, 8'hE0, 8'h30};
    for (int u = 0; u < 2; u++) begin
      rst_n[u] = 0;
      rx_empty[u] = 0;
      r_data[u] = 8'hAA;
      tx_full[u] = 0;
    end
    tick(3);
    @(negedge clk);
    for (int u = 0; u < 2; u++) chk($sformatf("rst_rd_gated%0d", u), rd[u], 0);
    tick();
    for (int u = 0; u < 2; u++) begin
      rx_empty[u] = 1;
      rst_n[u] = 1;
    end
    tick();
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("rst_busy%0d", u), busy[u], 0);
      chk($sformatf("rst_alu_a%0d", u), alu_a[u], 0);
      chk($sformatf("rst_alu_b%0d", u), alu_b[u], 0);
      chk($sformatf("rst_alu_op%0d", u), alu_op[u], 0);
      chk($sformatf("rst_w_data%0d", u), w_data[u], 0);
      chk($sformatf("rst_err%0d", u), err[u], 0);
    end
    for (int i = 0; i < 9; i++)
      frame(1, $sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].opb, vt[i].res);
    put_byte(0, 8'h05, p1);
    rx_empty[0] = 1;
    tick(100);
    chk("slow_busy", busy[0], 1);
    tick(100);
    put_byte(0, 8'h03, p2);
    rx_empty[0] = 1;
    tick(200);
    put_byte(0, 8'h20, p3);
    rx_empty[0] = 1;
    wait_push(0, 20, pc, d);
    chk("slow_result", d, 8'h08);
    chk("slow_latency", pc - p3, 2);
    chk("slow_no_err", errs[0], 0);
    n0 = pushes[1];
    e0 = errs[1];
    put_byte(1, 8'h11, p1);
    rx_empty[1] = 1;
    tick(60);
    chk("tmo_b_pulses", errs[1] - e0, 1);
    chk("tmo_b_at", err_cyc[1] - p1, 51);
    chk("tmo_b_busy", busy[1], 0);
    chk("tmo_b_a_kept", alu_a[1], 8'h11);
    chk("tmo_b_b_kept", alu_b[1], 8'h20);
    chk("tmo_b_nopush", pushes[1] - n0, 0);
    frame(1, "after_tmo", 8'h0F, 8'hF0, 8'h24, 8'h00);
    e0 = errs[1];
    put_byte(1, 8'h21, p1);
    rx_empty[1] = 1;
    tick(49);
    put_byte(1, 8'h02, p2);
    put_byte(1, 8'h20, p3);
    rx_empty[1] = 1;
    wait_push(1, 20, pc, d);
    chk("edge49_gap", p2 - p1, 50);
    chk("edge49_result", d, 8'h23);
    chk("edge49_no_err", errs[1] - e0, 0);
    n0 = pushes[1];
    put_byte(1, 8'h44, p1);
    put_byte(1, 8'h55, p2);
    rx_empty[1] = 1;
    tick(60);
    chk("tmo_op_pulses", errs[1] - e0, 1);
    chk("tmo_op_busy", busy[1], 0);
    chk("tmo_op_b", alu_b[1], 8'h55);
    chk("tmo_op_op_kept", alu_op[1], 8'h20);
    chk("tmo_op_nopush", pushes[1] - n0, 0);
    tx_full[1] = 1;
    n0 = pushes[1];
    put_byte(1, 8'h30, p1);
    put_byte(1, 8'h0C, p2);
    put_byte(1, 8'h25, p3);
    r_data[1] = 8'h99;
    rx_empty[1] = 0;
    q0 = pops[1];
    tick(2);
    chk("full_w_early", w_data[1], 8'h3C);
    tick(28);
    chk("full_w_late", w_data[1], 8'h3C);
    chk("full_nopush", pushes[1] - n0, 0);
    chk("full_nopop", pops[1] - q0, 0);
    chk("full_busy", busy[1], 1);
    tx_full[1] = 0;
    wait_push(1, 5, pc, d);
    chk("full_release_result", d, 8'h3C);
    chk("full_release_one", pushes[1] - n0, 1);
    put_byte(1, 8'h99, p1);
    put_byte(1, 8'h01, p2);
    put_byte(1, 8'h20, p3);
    rx_empty[1] = 1;
    wait_push(1, 20, pc, d);
    chk("full_next_result", d, 8'h9A);
    chk("full_next_count", pushes[1] - n0, 2);
    n0 = pushes[1];
    put_byte(1, 8'h30, p1);
    put_byte(1, 8'h40, p2);
    rst_n[1] = 0;
    r_data[1] = 8'h20;
    rx_empty[1] = 0;
    @(negedge clk);
    chk("midrst_no_pop", rd[1], 0);
    tick();
    rst_n[1] = 1;
    rx_empty[1] = 1;
    chk("midrst_busy", busy[1], 0);
    chk("midrst_a", alu_a[1], 0);
    chk("midrst_b", alu_b[1], 0);
    tick(10);
    chk("midrst_nopush", pushes[1] - n0, 0);
    frame(1, "after_rst", 8'h07, 8'h02, 8'h22, 8'h05);
    chk("proto_viol0", viol[0], 0);
    chk("proto_viol1", viol[1], 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
